// File: rtl/car_lanes_collision_if.sv
// Handshake bundle between the frog movement block, the car/collision block and the renderer.
// master drives the frog-side inputs; slave is the car/collision block.
interface car_lanes_collision_if #(
  parameter int NUM_LANES = 4
);
  logic                   i_Game_Active;
  logic [9:0]             i_Frog_X;
  logic [9:0]             i_Frog_Y;
  logic                   i_Level_Up;
  logic                   o_Has_Collided;
  logic [10*NUM_LANES-1:0] o_Car_X;
  logic [2:0]             o_Level;
  logic [1:0]             o_Lives;
  logic                   o_Game_Over;

  modport master (
    output i_Game_Active, i_Frog_X, i_Frog_Y, i_Level_Up,
    input  o_Has_Collided, o_Car_X, o_Level, o_Lives, o_Game_Over
  );

  modport slave (
    input  i_Game_Active, i_Frog_X, i_Frog_Y, i_Level_Up,
    output o_Has_Collided, o_Car_X, o_Level, o_Lives, o_Game_Over
  );
endinterface

// File: rtl/car_lanes_collision.sv
// Car traffic generator with frog/car overlap detection, level, lives and game-over tracking.
//   state     | meaning
//   IDLE      | no game running, waiting for i_Game_Active
//   RUN       | cars moving, overlap detection active
//   HIT       | single-cycle collision pulse, lives decrement
//   COOLDOWN  | cars moving, waiting for frog respawn at base position
//   GAME_OVER | lives exhausted, cars frozen until game deactivates
module car_lanes_collision #(
  parameter int NUM_LANES         = 4,
  parameter int TILE_SIZE         = 32,
  parameter int CAR_WIDTH         = 64,
  parameter int H_VISIBLE_AREA    = 640,
  parameter int LANE_Y_BASE       = 96,
  parameter int c_X_BASE_POSITION = 320,
  parameter int c_Y_BASE_POSITION = 384,
  parameter int MOVE_PERIOD       = 1562500,
  parameter int MAX_LEVEL         = 7,
  parameter int LIVES_INI         = 3
) (
  input logic             i_Clk,
  input logic             i_Reset,
  car_lanes_collision_if.slave bus
);
  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  typedef enum logic [2:0] {IDLE, RUN, HIT, COOLDOWN, GAME_OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [9:0]       car_x     [NUM_LANES];
  logic [9:0]       car_x_nxt [NUM_LANES];
  logic [2:0]       level;
  logic [1:0]       lives;
  logic             has_collided;
  logic             game_over;
  logic             tick;
  logic             overlap;
  logic             at_base;
  logic [10:0]      step;

  always_comb begin
    logic [10:0] nx;
    logic [10:0] cx;
    nx      = '0;
    cx      = '0;
    step    = 11'd1 + {8'd0, level};
    tick    = (tick_cnt == CNT_W'(MOVE_PERIOD - 1));
    at_base = (bus.i_Frog_X == 10'(c_X_BASE_POSITION)) &&
              (bus.i_Frog_Y == 10'(c_Y_BASE_POSITION));
    overlap = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cx = {1'b0, car_x[k]};
      // even lanes travel right, odd lanes travel left, both wrap at the screen edge
      if (k % 2 == 0) begin
        nx = cx + step;
        if (nx >= 11'(H_VISIBLE_AREA)) nx = nx - 11'(H_VISIBLE_AREA);
      end else if (cx < step) begin
        nx = cx + 11'(H_VISIBLE_AREA) - step;
      end else begin
        nx = cx - step;
      end
      car_x_nxt[k] = nx[9:0];
      if (({1'b0, bus.i_Frog_Y} == 11'(LANE_Y_BASE + k * 2 * TILE_SIZE)) &&
          ({1'b0, bus.i_Frog_X} < cx + 11'(CAR_WIDTH)) &&
          (cx < {1'b0, bus.i_Frog_X} + 11'(TILE_SIZE)))
        overlap = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= IDLE;
      has_collided <= 1'b0;
      level        <= '0;
      lives        <= 2'(LIVES_INI);
      game_over    <= 1'b0;
      tick_cnt     <= '0;
      for (int k = 0; k < NUM_LANES; k++) car_x[k] <= 10'((k * 160) % H_VISIBLE_AREA);
    end else if (state != IDLE && !bus.i_Game_Active) begin
      state        <= IDLE;
      has_collided <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Game_Active) begin
            state    <= RUN;
            level    <= '0;
            lives    <= 2'(LIVES_INI);
            tick_cnt <= '0;
            for (int k = 0; k < NUM_LANES; k++) car_x[k] <= 10'((k * 160) % H_VISIBLE_AREA);
          end
        end
        RUN, COOLDOWN: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) for (int k = 0; k < NUM_LANES; k++) car_x[k] <= car_x_nxt[k];
          if (bus.i_Level_Up && (level < 3'(MAX_LEVEL))) level <= level + 1'b1;
          if (state == RUN && overlap) begin
            state        <= HIT;
            has_collided <= 1'b1;
          end else if (state == COOLDOWN && at_base) begin
            state <= RUN;
          end
        end
        HIT: begin
          has_collided <= 1'b0;
          lives        <= lives - 1'b1;
          if (lives == 2'd1) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            state <= COOLDOWN;
          end
        end
        GAME_OVER: ;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_car_out
    assign bus.o_Car_X[10*g +: 10] = car_x[g];
  end

  assign bus.o_Has_Collided = has_collided;
  assign bus.o_Level        = level;
  assign bus.o_Lives        = lives;
  assign bus.o_Game_Over    = game_over;
endmodule

// File: tb/tb_car_lanes_collision.sv
// Directed plus randomized bench for car_lanes_collision against a cycle-level behavioural game model.
module tb_car_lanes_collision;
  localparam int P  = 4;
  localparam int NL = 4;
  localparam int W  = 640;

  logic i_Clk;
  logic i_Reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  car_lanes_collision_if #(.NUM_LANES(NL)) bus ();

  car_lanes_collision #(.MOVE_PERIOD(P)) u_dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus.slave)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // behavioural model of the game
  string m_mode = "IDLE";
  int    m_lvl = 0, m_lives = 3, m_cnt = 0, m_hc = 0, m_go = 0;
  int    m_car [NL];

  task automatic model_init_cars();
    for (int k = 0; k < NL; k++) m_car[k] = (k * 160) % W;
  endtask

  task automatic model_advance();
    if (m_cnt == P - 1) begin
      m_cnt = 0;
      for (int k = 0; k < NL; k++)
        if (k % 2 == 0) m_car[k] = (m_car[k] + 1 + m_lvl) % W;
        else            m_car[k] = (m_car[k] - (1 + m_lvl) + W) % W;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_step();
    int fx, fy;
    bit hit;
    fx  = int'(bus.i_Frog_X);
    fy  = int'(bus.i_Frog_Y);
    hit = 0;
    if (i_Reset) begin
      m_mode = "IDLE"; m_hc = 0; m_lvl = 0; m_lives = 3; m_go = 0; m_cnt = 0;
      model_init_cars();
    end else if (m_mode != "IDLE" && !bus.i_Game_Active) begin
      m_mode = "IDLE"; m_hc = 0; m_go = 0;
    end else if (m_mode == "IDLE") begin
      if (bus.i_Game_Active) begin
        m_mode = "RUN"; m_lvl = 0; m_lives = 3; m_cnt = 0;
        model_init_cars();
      end
    end else if (m_mode == "RUN" || m_mode == "COOLDOWN") begin
      for (int k = 0; k < NL; k++)
        if (fy == 96 + 64 * k && fx < m_car[k] + 64 && m_car[k] < fx + 32) hit = 1;
      model_advance();
      if (bus.i_Level_Up && m_lvl < 7) m_lvl++;
      if (m_mode == "RUN") begin
        if (hit) begin m_mode = "HIT"; m_hc = 1; end
      end else if (fx == 320 && fy == 384) begin
        m_mode = "RUN";
      end
    end else if (m_mode == "HIT") begin
      m_hc = 0;
      if (m_lives == 1) begin m_mode = "GAME_OVER"; m_go = 1; end
      else m_mode = "COOLDOWN";
      m_lives--;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("has_collided", 32'(bus.o_Has_Collided), m_hc);
    check("level",        32'(bus.o_Level),        m_lvl);
    check("lives",        32'(bus.o_Lives),        m_lives);
    check("game_over",    32'(bus.o_Game_Over),    m_go);
    for (int k = 0; k < NL; k++)
      check($sformatf("car%0d", k), 32'(bus.o_Car_X[10*k +: 10]), m_car[k]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_Clk);
    #1;
    compare_all();
  endtask

  // advance until the cycle in which the cars move
  task automatic run_until_tick();
    bit will_tick;
    for (int g = 0; g < 4 * P; g++) begin
      will_tick = (m_mode == "RUN" || m_mode == "COOLDOWN") && (m_cnt == P - 1);
      cycle();
      if (will_tick) break;
    end
  endtask

  task automatic set_frog(input int x, input int y);
    bus.i_Frog_X = 10'(x);
    bus.i_Frog_Y = 10'(y);
  endtask

  task automatic hit_on_lane1();
    set_frog(m_car[1], 160);
    cycle();
    check("hit_pulse", 32'(bus.o_Has_Collided), 1);
    cycle();
    check("hit_pulse_end", 32'(bus.o_Has_Collided), 0);
  endtask

  initial begin
    int c0, pulses, ch, lane, x;
    int saved [NL];
    i_Reset = 1'b1;
    bus.i_Game_Active = 1'b0;
    bus.i_Level_Up    = 1'b0;
    set_frog(320, 384);
    cycle();
    cycle();
    check("rst_lives", 32'(bus.o_Lives), 3);
    check("rst_level", 32'(bus.o_Level), 0);
    check("rst_hc",    32'(bus.o_Has_Collided), 0);
    check("rst_go",    32'(bus.o_Game_Over), 0);
    check("rst_car3",  32'(bus.o_Car_X[39:30]), 480);

    i_Reset = 1'b0;
    bus.i_Game_Active = 1'b1;
    repeat (9) cycle();
    check("start_car0", 32'(bus.o_Car_X[9:0]),   2);
    check("start_car1", 32'(bus.o_Car_X[19:10]), 158);
    check("start_car2", 32'(bus.o_Car_X[29:20]), 322);
    check("start_car3", 32'(bus.o_Car_X[39:30]), 478);

    // lane 1 wraps 0 -> 639, lane 0 wraps 639 -> 0
    for (int g = 0; g < 4000 && m_car[1] != 0; g++) cycle();
    run_until_tick();
    check("wrap_lane1", 32'(bus.o_Car_X[19:10]), 639);
    for (int g = 0; g < 4000 && m_car[0] != 639; g++) cycle();
    run_until_tick();
    check("wrap_lane0", 32'(bus.o_Car_X[9:0]), 0);

    // first collision at fixed frog position
    set_frog(160, 160);
    for (int g = 0; g < 4000 && m_hc == 0; g++) cycle();
    check("hit1_seen", 32'(bus.o_Has_Collided), 1);
    pulses = 0;
    for (int g = 0; g < 20; g++) begin
      cycle();
      if (bus.o_Has_Collided) pulses++;
    end
    check("hit1_single_pulse", 32'(pulses), 0);
    check("hit1_lives", 32'(bus.o_Lives), 2);
    set_frog(320, 384);
    cycle();

    // level saturation and faster cars
    for (int i = 0; i < 9; i++) begin
      bus.i_Level_Up = 1'b1;
      cycle();
      bus.i_Level_Up = 1'b0;
      cycle();
    end
    check("level_sat", 32'(bus.o_Level), 7);
    c0 = m_car[0];
    run_until_tick();
    check("step8_car0", 32'(bus.o_Car_X[9:0]), (c0 + 8) % W);

    // hits two and three end the game
    hit_on_lane1();
    check("hit2_lives", 32'(bus.o_Lives), 1);
    set_frog(320, 384);
    cycle();
    hit_on_lane1();
    check("go_lives", 32'(bus.o_Lives), 0);
    check("go_flag",  32'(bus.o_Game_Over), 1);
    for (int k = 0; k < NL; k++) saved[k] = m_car[k];
    set_frog(320, 384);
    repeat (12) cycle();
    for (int k = 0; k < NL; k++)
      check($sformatf("frozen_car%0d", k), 32'(bus.o_Car_X[10*k +: 10]), saved[k]);
    bus.i_Game_Active = 1'b0;
    cycle();
    check("go_cleared", 32'(bus.o_Game_Over), 0);
    bus.i_Game_Active = 1'b1;
    cycle();
    check("restart_lives", 32'(bus.o_Lives), 3);
    check("restart_level", 32'(bus.o_Level), 0);
    check("restart_car1",  32'(bus.o_Car_X[19:10]), 160);

    // reset while in cooldown with level 3
    for (int i = 0; i < 3; i++) begin
      bus.i_Level_Up = 1'b1;
      cycle();
    end
    bus.i_Level_Up = 1'b0;
    hit_on_lane1();
    set_frog(0, 0);
    cycle();
    check("pre_rst_level", 32'(bus.o_Level), 3);
    i_Reset = 1'b1;
    cycle();
    i_Reset = 1'b0;
    check("cd_rst_level", 32'(bus.o_Level), 0);
    check("cd_rst_lives", 32'(bus.o_Lives), 3);
    check("cd_rst_hc",    32'(bus.o_Has_Collided), 0);
    check("cd_rst_car0",  32'(bus.o_Car_X[9:0]), 0);
    set_frog(320, 384);
    repeat (3) cycle();

    // randomized play
    for (int g = 0; g < 3000; g++) begin
      i_Reset           = ($urandom_range(0, 199) == 0);
      bus.i_Game_Active = ($urandom_range(0, 99) >= 2);
      bus.i_Level_Up    = ($urandom_range(0, 15) == 0);
      ch = $urandom_range(0, 5);
      if (ch <= 1) begin
        set_frog(320, 384);
      end else if (ch <= 4) begin
        lane = $urandom_range(0, NL - 1);
        x = m_car[lane] + $urandom_range(0, 112) - 40;
        if (x < 0) x = 0;
        set_frog(x, 96 + 64 * lane);
      end else begin
        set_frog($urandom_range(0, 1023), 96 + 64 * $urandom_range(0, NL - 1));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
